// File: rtl/stop_capture_fifo.sv
// stop_capture_fifo
//   Consumer stage for the start/stop mod-MOD counter. While armed, it counts
//   counter wrap-arounds. On the rising edge of the delayed stop it captures an
//   interval record {wraps, count, total} into a first-word-fall-through FIFO.
//   The FIFO drains over a valid/ready handshake.
// Ports
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   start            arms the capture, or re-arms it when already armed
//   count_in         value of the upstream counter (0..MOD-1)
//   stop_d2          delayed stop level; only its rising edge captures
//   out_ready        the consumer accepts the head record
//   out_valid        a head record is present
//   out_wraps/out_count/out_total  head record (all zero when the FIFO is empty)
//   fifo_level       number of entries held, 0..DEPTH
//   overflow         sticky; set when a capture is dropped while the FIFO is full
//   clr_ovf          synchronous clear of overflow (a new set wins over the clear)
module stop_capture_fifo #(
    parameter int unsigned MOD     = 14,
    parameter int unsigned WRAP_W  = 8,
    parameter int unsigned TOTAL_W = 12,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [3:0]                      count_in,
    input  logic                            stop_d2,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [WRAP_W-1:0]               out_wraps,
    output logic [3:0]                      out_count,
    output logic [TOTAL_W-1:0]              out_total,
    output logic [$clog2(DEPTH):0]          fifo_level,
    output logic                            overflow,
    input  logic                            clr_ovf
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = WRAP_W + CNT_W + TOTAL_W;

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MOD - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic [CNT_W-1:0]   prev_count_q;
    logic               stop_q;

    logic               wrap_now_c;
    logic               stop_rise_c;
    logic               capture_c;
    logic [WRAP_W-1:0]  cap_wraps_c;
    logic [TOTAL_W-1:0] cap_total_c;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               ovf_q;
    logic               empty_c, full_c, pop_c, push_c, drop_c;
    logic [ENT_W-1:0]   head_c;

    // Edge and wrap detection from previous-cycle copies of the inputs.
    assign wrap_now_c  = (prev_count_q == LAST_CNT) && (count_in == '0);
    assign stop_rise_c = stop_d2 & ~stop_q;

    // The wrap count includes a wrap that lands in the current cycle and saturates.
    assign cap_wraps_c = (wrap_now_c && (wrap_cnt_q != WRAP_MAX)) ? wrap_cnt_q + WRAP_W'(1)
                                                                  : wrap_cnt_q;
    assign cap_total_c = TOTAL_W'(cap_wraps_c) * TOTAL_W'(MOD) + TOTAL_W'(count_in);

    // Next-state logic for the IDLE/ARMED controller.
    always_comb begin
        state_d    = state_q;
        wrap_cnt_d = wrap_cnt_q;
        capture_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ARMED;
                    wrap_cnt_d = '0;
                end
            end
            S_ARMED: begin
                capture_c = stop_rise_c;
                if (start) begin
                    wrap_cnt_d = '0;
                end else if (stop_rise_c) begin
                    state_d = S_IDLE;
                end else begin
                    wrap_cnt_d = cap_wraps_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller and input-history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wrap_cnt_q   <= '0;
            prev_count_q <= '0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrap_cnt_q   <= wrap_cnt_d;
            prev_count_q <= count_in;
            stop_q       <= stop_d2;
        end
    end

    // FIFO control. When the FIFO is full, a pop in the same cycle frees the slot for the push.
    assign empty_c = (level_q == '0);
    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign pop_c   = ~empty_c & out_ready;
    assign push_c  = capture_c & (~full_c | pop_c);
    assign drop_c  = capture_c & full_c & ~pop_c;

    // Storage needs no reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= {cap_wraps_c, count_in, cap_total_c};
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_c && !pop_c)      level_q <= level_q + LVL_W'(1);
            else if (pop_c && !push_c) level_q <= level_q - LVL_W'(1);
            if (drop_c)       ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    // Fall-through head view.
    assign head_c     = mem[rd_ptr_q];
    assign out_valid  = ~empty_c;
    assign out_wraps  = empty_c ? '0 : head_c[ENT_W-1 -: WRAP_W];
    assign out_count  = empty_c ? '0 : head_c[TOTAL_W +: CNT_W];
    assign out_total  = empty_c ? '0 : head_c[TOTAL_W-1:0];
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stop_capture_fifo.sv
// Bench for stop_capture_fifo: directed scenarios followed by random traffic.
// A queue-based interval model is compared against the DUT outputs on every falling edge.
module tb_stop_capture_fifo;

    localparam int MOD = 14;

    logic        clk = 1'b0;
    logic        reset, start, stop_d2, out_ready, clr_ovf;
    logic [3:0]  count_in;
    logic        out_valid, overflow;
    logic [7:0]  out_wraps;
    logic [3:0]  out_count;
    logic [11:0] out_total;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    stop_capture_fifo dut (
        .clk(clk), .reset(reset), .start(start), .count_in(count_in),
        .stop_d2(stop_d2), .out_ready(out_ready), .out_valid(out_valid),
        .out_wraps(out_wraps), .out_count(out_count), .out_total(out_total),
        .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: armed flag, running wrap count and a queue of records.
    typedef struct { int w; int c; int t; } rec_t;
    rec_t mq[$];
    bit   m_armed, m_ovf, m_stopq;
    int   m_wraps, m_prev;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_armed = 0; m_ovf = 0; m_stopq = 0; m_wraps = 0; m_prev = 0;
        end else begin
            bit   wrapped, rise, popped, dropped;
            rec_t r;
            wrapped = (m_prev == MOD - 1) && (int'(count_in) == 0);
            rise    = stop_d2 && !m_stopq;
            popped  = (mq.size() > 0) && out_ready;
            dropped = 0;
            if (popped) void'(mq.pop_front());
            if (m_armed && rise) begin
                r.w = (m_wraps + int'(wrapped) > 255) ? 255 : m_wraps + int'(wrapped);
                r.c = int'(count_in);
                r.t = r.w * MOD + r.c;
                if (mq.size() < 4) mq.push_back(r);
                else dropped = 1;
            end
            if (!m_armed) begin
                if (start) begin m_armed = 1; m_wraps = 0; end
            end else if (start) begin
                m_wraps = 0;
            end else if (rise) begin
                m_armed = 0;
            end else if (wrapped && m_wraps < 255) begin
                m_wraps++;
            end
            if (dropped) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_prev  = int'(count_in);
            m_stopq = stop_d2;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit has;
        has = mq.size() > 0;
        chk("out_valid",  int'(out_valid),  int'(has));
        chk("out_wraps",  int'(out_wraps),  has ? mq[0].w : 0);
        chk("out_count",  int'(out_count),  has ? mq[0].c : 0);
        chk("out_total",  int'(out_total),  has ? mq[0].t : 0);
        chk("fifo_level", int'(fifo_level), mq.size());
        chk("overflow",   int'(overflow),   int'(m_ovf));
    end

    // Apply one cycle of inputs and return just after the following falling edge.
    task automatic cyc(input bit st, input int c, input bit sd, input bit rdy, input bit clr);
        start = st; count_in = 4'(c); stop_d2 = sd; out_ready = rdy; clr_ovf = clr;
        @(negedge clk); #1;
    endtask

    task automatic interval(input int c);
        cyc(1, 0, 0, 0, 0);
        cyc(0, c, 0, 0, 0);
        cyc(0, c, 1, 0, 0);
        cyc(0, c, 0, 0, 0);
    endtask

    initial begin
        bit sdv;
        int rc;
        reset = 1; start = 0; count_in = 0; stop_d2 = 0; out_ready = 0; clr_ovf = 0;
        @(negedge clk); #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ovf",   int'(overflow), 0);
        reset = 0;

        // T1: five counts, then stop
        cyc(1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(0, k, 0, 0, 0);
        cyc(0, 5, 1, 0, 0);
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_wraps", int'(out_wraps), 0);
        chk("t1_count", int'(out_count), 5);
        chk("t1_total", int'(out_total), 5);
        cyc(0, 5, 1, 1, 0);
        cyc(0, 5, 0, 0, 0);

        // T2: 30 counts, two wraps
        cyc(1, 0, 0, 0, 0);
        for (int k = 1; k <= 30; k++) cyc(0, k % MOD, 0, 0, 0);
        cyc(0, 2, 1, 0, 0);
        chk("t2_wraps", int'(out_wraps), 2);
        chk("t2_count", int'(out_count), 2);
        chk("t2_total", int'(out_total), 30);
        cyc(0, 2, 1, 1, 0);
        chk("t2_popped", int'(out_valid), 0);
        cyc(0, 2, 0, 0, 0);

        // T3: five captures into a four-entry FIFO
        for (int i = 0; i < 5; i++) interval(i + 1);
        chk("t3_level", int'(fifo_level), 4);
        chk("t3_ovf",   int'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", int'(out_count), i + 1);
            cyc(0, 0, 0, 1, 0);
        end
        chk("t3_empty", int'(out_valid), 0);
        cyc(0, 0, 0, 0, 1);
        chk("t3_clr", int'(overflow), 0);

        // T4: start and stop rise in the same armed cycle, then a second stop
        cyc(1, 0, 0, 0, 0);
        cyc(0, 3, 0, 0, 0);
        cyc(1, 3, 1, 0, 0);
        chk("t4_level1", int'(fifo_level), 1);
        chk("t4_total1", int'(out_total), 3);
        cyc(0, 4, 0, 0, 0);
        cyc(0, 13, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t4_level2", int'(fifo_level), 2);
        cyc(0, 0, 0, 1, 0);
        chk("t4_wraps2", int'(out_wraps), 1);
        chk("t4_total2", int'(out_total), 14);
        cyc(0, 0, 0, 1, 0);

        // Wrap-count saturation: 260 wraps clamp to 255
        cyc(1, 0, 0, 0, 0);
        for (int k = 1; k <= 260 * MOD; k++) cyc(0, k % MOD, 0, 0, 0);
        cyc(0, 13, 1, 0, 0);
        chk("sat_wraps", int'(out_wraps), 255);
        chk("sat_total", int'(out_total), 3583);
        cyc(0, 13, 0, 1, 0);

        // T5: a multi-cycle stop captures once; a stop rising while idle captures nothing
        cyc(1, 0, 0, 0, 0);
        cyc(0, 6, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 6, 1, 0, 0);
        cyc(0, 6, 0, 0, 0);
        chk("t5_once", int'(fifo_level), 1);
        cyc(0, 7, 1, 0, 0);
        cyc(0, 7, 0, 0, 0);
        chk("t5_idle", int'(fifo_level), 1);
        cyc(0, 7, 0, 1, 0);

        // T6: reset while records are queued and draining
        for (int i = 0; i < 5; i++) interval(i + 2);
        cyc(0, 0, 0, 1, 0);
        chk("t6_pre", int'(fifo_level), 3);
        reset = 1;
        cyc(0, 0, 0, 1, 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_level", int'(fifo_level), 0);
        chk("t6_ovf",   int'(overflow), 0);
        reset = 0;

        // Random traffic: mostly counting, with occasional jumps, restarts and resets
        sdv = 0; rc = 0;
        for (int n = 0; n < 3000; n++) begin
            rc = ($urandom % 8 == 0) ? int'($urandom % MOD) : (rc + 1) % MOD;
            if ($urandom % 4 == 0) sdv = ~sdv;
            reset = ($urandom % 400 == 0);
            cyc($urandom % 16 == 0, rc, sdv, $urandom % 3 == 0, $urandom % 32 == 0);
        end
        reset = 0;
        cyc(0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
